// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: sequences header decode,
// payload/parity loads and full stalls, with per-FIFO soft-reset abort.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] LOAD_PARITY        = 3'd5;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

  logic [2:0] state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] empty_idx;
  logic       empty_sel;
  logic       srst_sel;
  logic       hdr_ok;

  // While decoding, the address being presented is the one that matters.
  assign empty_idx = (state_q == DECODE_ADDRESS) ? data_in : addr_q;

  always_comb begin
    empty_sel = 1'b0;
    case (empty_idx)
      2'd0:    empty_sel = fifo_empty_0;
      2'd1:    empty_sel = fifo_empty_1;
      2'd2:    empty_sel = fifo_empty_2;
      default: empty_sel = 1'b0;
    endcase
  end

  always_comb begin
    srst_sel = 1'b0;
    case (addr_q)
      2'd0:    srst_sel = soft_reset_0;
      2'd1:    srst_sel = soft_reset_1;
      2'd2:    srst_sel = soft_reset_2;
      default: srst_sel = 1'b0;
    endcase
  end

  assign hdr_ok = pkt_valid && (data_in != 2'd3);

  always_comb begin
    addr_d = addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid)
      addr_d = data_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok && empty_sel)       state_d = LOAD_FIRST_DATA;
        else if (hdr_ok)               state_d = WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA:                 state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)                 state_d = FIFO_FULL_STATE;
        else if (!pkt_valid)           state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full)                state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)               state_d = DECODE_ADDRESS;
        else if (low_pkt_valid)        state_d = LOAD_PARITY;
        else                           state_d = LOAD_DATA;
      end
      LOAD_PARITY:                     state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full)                 state_d = FIFO_FULL_STATE;
        else                           state_d = DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_sel)                 state_d = LOAD_FIRST_DATA;
      end
      default:                         state_d = DECODE_ADDRESS;
    endcase
    // A timeout on the addressed FIFO aborts the packet from any active state.
    if (srst_sel && state_q != DECODE_ADDRESS)
      state_d = DECODE_ADDRESS;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    full_state    = (state_q == FIFO_FULL_STATE);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: expected output vectors are queued as each
// cycle's stimulus is applied and compared after the following clock edge.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state;
  logic       write_enb_reg, rst_int_reg, busy;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  // {detect_add, lfd, ld, full, laf, write_enb_reg, rst_int_reg, busy}
  localparam logic [7:0] DA  = 8'b1000_0000;
  localparam logic [7:0] LFD = 8'b0100_0001;
  localparam logic [7:0] LD  = 8'b0010_0100;
  localparam logic [7:0] FFS = 8'b0001_0001;
  localparam logic [7:0] LAF = 8'b0000_1101;
  localparam logic [7:0] LP  = 8'b0000_0101;
  localparam logic [7:0] CPE = 8'b0000_0011;
  localparam logic [7:0] WTE = 8'b0000_0001;

  logic [7:0] obs;
  assign obs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                write_enb_reg, rst_int_reg, busy};

  logic [7:0] exp_q[$];
  string      name_q[$];
  int checks = 0;
  int passed = 0;
  int wen_cnt = 0;

  task automatic idle();
    pkt_valid = 0; data_in = 0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
  endtask

  // Current inputs are applied; queue what the outputs must be after the edge.
  task automatic cyc(input string name, input logic [7:0] exp);
    logic [7:0] e;
    string n;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    checks++;
    if (obs !== e)
      $display("FAIL %s: got %b expected %b", n, obs, e);
    else
      passed++;
    if (write_enb_reg === 1'b1) wen_cnt++;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    #1;
    checks++;
    if (obs !== DA) $display("FAIL reset_state: got %b expected %b", obs, DA);
    else passed++;
    @(posedge clock); #1;
    resetn = 1;
    cyc("reset_idle", DA);
  endtask

  task automatic test_normal();
    wen_cnt = 0;
    pkt_valid = 1; data_in = 2'd1;
    cyc("norm_lfd", LFD);
    data_in = 2'd3;
    cyc("norm_ld1", LD);
    cyc("norm_ld2", LD);
    cyc("norm_ld3", LD);
    pkt_valid = 0; data_in = 2'd0;
    cyc("norm_lp", LP);
    cyc("norm_cpe", CPE);
    cyc("norm_da", DA);
    checks++;
    if (wen_cnt !== 4) $display("FAIL norm_wen_cycles: got %0d expected 4", wen_cnt);
    else passed++;
  endtask

  task automatic test_wait_empty();
    fifo_empty_2 = 0;
    pkt_valid = 1; data_in = 2'd2;
    cyc("wait_wte1", WTE);
    data_in = 2'd0;
    cyc("wait_wte2", WTE);
    cyc("wait_wte3", WTE);
    cyc("wait_wte4", WTE);
    fifo_empty_2 = 1;
    cyc("wait_lfd", LFD);
    cyc("wait_ld", LD);
    pkt_valid = 0;
    cyc("wait_lp", LP);
    cyc("wait_cpe", CPE);
    cyc("wait_da", DA);
  endtask

  task automatic test_full();
    pkt_valid = 1; data_in = 2'd0;
    cyc("full_lfd", LFD);
    cyc("full_ld", LD);
    fifo_full = 1;
    cyc("full_ffs1", FFS);
    cyc("full_ffs2", FFS);
    cyc("full_ffs3", FFS);
    fifo_full = 0;
    cyc("full_laf1", LAF);
    pkt_valid = 0; low_pkt_valid = 1;
    cyc("full_laf_lpv_lp", LP);
    low_pkt_valid = 0; fifo_full = 1;
    cyc("full_cpe", CPE);
    cyc("full_cpe_to_ffs", FFS);
    fifo_full = 0;
    cyc("full_laf2", LAF);
    pkt_valid = 1;
    cyc("full_laf_to_ld", LD);
    pkt_valid = 0; fifo_full = 1;
    cyc("full_beats_pv_low", FFS);
    fifo_full = 0;
    cyc("full_laf3", LAF);
    parity_done = 1; low_pkt_valid = 1;
    cyc("full_pdone_wins", DA);
    parity_done = 0; low_pkt_valid = 0;
    cyc("full_da_idle", DA);
  endtask

  task automatic test_invalid();
    pkt_valid = 1; data_in = 2'd3;
    cyc("inv_stay1", DA);
    cyc("inv_stay2", DA);
    pkt_valid = 0; data_in = 2'd0;
    cyc("inv_idle", DA);
  endtask

  task automatic test_soft_reset();
    pkt_valid = 1; data_in = 2'd0; soft_reset_0 = 1;
    cyc("srst_ignored_in_da", LFD);
    cyc("srst_aborts_lfd", DA);
    soft_reset_0 = 0;
    cyc("srst_hdr", LFD);
    cyc("srst_ld", LD);
    fifo_full = 1;
    cyc("srst_ffs", FFS);
    soft_reset_1 = 1;
    cyc("srst_other_port", FFS);
    soft_reset_1 = 0; soft_reset_0 = 1;
    cyc("srst_beats_full", DA);
    soft_reset_0 = 0; fifo_full = 0; pkt_valid = 0;
    cyc("srst_idle", DA);
  endtask

  task automatic test_reset_mid();
    pkt_valid = 1; data_in = 2'd1;
    cyc("rmid_lfd", LFD);
    cyc("rmid_ld", LD);
    #2;
    resetn = 0;
    #1;
    checks++;
    if (obs !== DA) $display("FAIL rmid_async: got %b expected %b", obs, DA);
    else passed++;
    @(posedge clock); #1;
    pkt_valid = 0;
    resetn = 1;
    cyc("rmid_release", DA);
  endtask

  task automatic test_back_to_back();
    pkt_valid = 1; data_in = 2'd2;
    cyc("b2b_lfd", LFD);
    cyc("b2b_ld", LD);
    pkt_valid = 0;
    cyc("b2b_lp", LP);
    pkt_valid = 1; data_in = 2'd1;
    cyc("b2b_cpe", CPE);
    cyc("b2b_da", DA);
    cyc("b2b_lfd2", LFD);
    pkt_valid = 0;
    cyc("b2b_ld2", LD);
    cyc("b2b_lp2", LP);
    cyc("b2b_cpe2", CPE);
    cyc("b2b_da2", DA);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_wait_empty();
    test_full();
    test_invalid();
    test_soft_reset();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
